vip_frame_ctrl: RTL and testbench

Frame-synchronous controller for the VIP pipeline: colour threshold, Sobel, erosion and dilation. It accepts CPU-side register writes and holds them in shadow registers. New settings reach the pipeline only at a start-of-frame (SOF), so a frame is never processed with mixed settings. It also gates the pixel stream into the pipeline on whole-frame boundaries and measures the incoming frame geometry. It sits between the camera/RGB565 source and the VIP pipeline input, and drives the pipeline's `sobel` threshold and output-stage select.

---
 rtl/vip_frame_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vip_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_ctrl.sv
`default_nettype none
// ============================================================================
// vip_frame_ctrl : shadowed VIP settings applied at SOF, whole-frame stream
//                  gating and incoming frame geometry measurement.
// Rev 1.0
// ============================================================================
module vip_frame_ctrl #(
  parameter logic [10:0] TH_DEF = 11'd100,
  parameter bit          VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] cfg_rdata,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [15:0] pre_rgb,
  output logic        pipe_frame_vsync,
  output logic        pipe_frame_hsync,
  output logic        pipe_frame_de,
  output logic [15:0] pipe_rgb,
  output logic [10:0] sobel_th,
  output logic [1:0]  out_sel,
  output logic        vip_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, pending_q;
  logic [1:0]  sel_sh_q, sel_q;
  logic [10:0] th_sh_q, th_q;
  logic        vs_q, hs_q, de_q, de_prev_q;
  logic [15:0] rgb_q, rdata_q, rdata_d;
  logic [11:0] run_len_q, line_len_q, lines_q, frame_lines_q, lines_d;
  logic        sof, gate, apply, de_fall;
  logic        wr_ctrl, wr_th, wr_frame;
  logic        unused_wdata;

  assign unused_wdata = ^cfg_wdata[15:11];

  // The registered vsync output doubles as the previous-vsync sample.
  assign sof      = (pre_frame_vsync == VS_POL) && (vs_q != VS_POL);
  assign de_fall  = de_prev_q && !pre_frame_de;
  assign wr_ctrl  = cfg_wr && (cfg_addr == 2'd0);
  assign wr_th    = cfg_wr && (cfg_addr == 2'd1);
  assign wr_frame = cfg_wr && (cfg_addr == 2'd3);
  assign lines_d  = (de_fall && (lines_q != 12'hFFF)) ? lines_q + 12'd1 : lines_q;

  always_comb begin
    state_d = state_q;
    gate    = 1'b0;
    apply   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (sof) begin
          gate    = 1'b1;
          apply   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        gate  = 1'b1;
        apply = sof;
        if (!en_q) state_d = S_DRAIN;
      end
      default: begin
        // Re-enable wins over closing: the open frame simply continues.
        if (en_q) begin
          gate    = 1'b1;
          state_d = S_RUN;
        end else if (sof) begin
          state_d = S_IDLE;
        end else begin
          gate = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rdata_d = 16'd0;
    case (cfg_addr)
      2'd0:    rdata_d = {13'd0, sel_sh_q, en_q};
      2'd1:    rdata_d = {5'd0, th_sh_q};
      2'd2:    rdata_d = {line_len_q, 1'b0, pending_q, state_q};
      default: rdata_d = {4'd0, frame_lines_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      en_q          <= 1'b0;
      sel_sh_q      <= 2'd0;
      th_sh_q       <= TH_DEF;
      pending_q     <= 1'b0;
      sel_q         <= 2'd0;
      th_q          <= TH_DEF;
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      de_q          <= 1'b0;
      rgb_q         <= 16'd0;
      de_prev_q     <= 1'b0;
      run_len_q     <= 12'd0;
      line_len_q    <= 12'd0;
      lines_q       <= 12'd0;
      frame_lines_q <= 12'd0;
      rdata_q       <= 16'd0;
    end else begin
      state_q <= state_d;
      if (wr_ctrl) begin
        en_q     <= cfg_wdata[0];
        sel_sh_q <= cfg_wdata[2:1];
      end
      if (wr_th) th_sh_q <= cfg_wdata[10:0];
      // A write coinciding with an apply keeps pending for the next SOF.
      if (wr_ctrl || wr_th) pending_q <= 1'b1;
      else if (apply)       pending_q <= 1'b0;
      if (apply) begin
        sel_q <= sel_sh_q;
        th_q  <= th_sh_q;
      end
      vs_q      <= pre_frame_vsync;
      hs_q      <= pre_frame_hsync;
      de_q      <= pre_frame_de && gate;
      rgb_q     <= pre_rgb;
      de_prev_q <= pre_frame_de;
      if (pre_frame_de) begin
        if (run_len_q != 12'hFFF) run_len_q <= run_len_q + 12'd1;
      end else begin
        run_len_q <= 12'd0;
      end
      if (de_fall) line_len_q <= run_len_q;
      if (sof) begin
        frame_lines_q <= lines_d;
        lines_q       <= 12'd0;
      end else begin
        lines_q <= lines_d;
        if (wr_frame) frame_lines_q <= 12'd0;
      end
      if (cfg_rd) rdata_q <= rdata_d;
    end
  end

  assign cfg_rdata        = rdata_q;
  assign pipe_frame_vsync = vs_q;
  assign pipe_frame_hsync = hs_q;
  assign pipe_frame_de    = de_q;
  assign pipe_rgb         = rgb_q;
  assign sobel_th         = th_q;
  assign out_sel          = sel_q;
  assign vip_busy         = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_vip_frame_ctrl.sv
`default_nettype none
// Bench for vip_frame_ctrl: random/directed frames against a cycle-level
// behavioural model, expectations queued and checked by a separate monitor.
module tb_vip_frame_ctrl;
  localparam logic [10:0] TH_DEF = 11'd100;
  localparam bit          VS_POL = 1'b1;
  localparam int IDLE = 0, WAIT_SOF = 1, RUN = 2, DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0, cfg_rd = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [15:0] cfg_rdata;
  logic        pre_frame_vsync = ~VS_POL;
  logic        pre_frame_hsync = 1'b0, pre_frame_de = 1'b0;
  logic [15:0] pre_rgb = 16'd0;
  logic        pipe_frame_vsync, pipe_frame_hsync, pipe_frame_de;
  logic [15:0] pipe_rgb;
  logic [10:0] sobel_th;
  logic [1:0]  out_sel;
  logic        vip_busy;

  always #5 clk = ~clk;

  vip_frame_ctrl #(.TH_DEF(TH_DEF), .VS_POL(VS_POL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
    .pre_frame_de(pre_frame_de), .pre_rgb(pre_rgb),
    .pipe_frame_vsync(pipe_frame_vsync), .pipe_frame_hsync(pipe_frame_hsync),
    .pipe_frame_de(pipe_frame_de), .pipe_rgb(pipe_rgb),
    .sobel_th(sobel_th), .out_sel(out_sel), .vip_busy(vip_busy)
  );

  typedef struct {
    bit          rst;
    logic        vs, hs, de;
    logic [15:0] rgb;
    logic [10:0] th;
    logic [1:0]  sel;
    logic        busy;
  } exp_t;

  exp_t        sq[$];
  logic [15:0] rq[$];
  int          n_chk = 0, n_err = 0;
  bit          rnd_on = 0;

  // Reference model state, plain integers
  int m_mode, m_sel_sh, m_th_sh, m_sel, m_th, m_run, m_len, m_lines, m_flines;
  bit m_en, m_pend, m_prev_vs, m_prev_de;

  function automatic int sat(int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] reg_value(logic [1:0] a);
    case (a)
      2'd0:    return 16'(m_sel_sh * 2 + int'(m_en));
      2'd1:    return 16'(m_th_sh);
      2'd2:    return 16'(m_len * 16 + int'(m_pend) * 4 + m_mode);
      default: return 16'(m_flines);
    endcase
  endfunction

  // Predicts the DUT outputs after the coming clock edge from current inputs.
  function automatic void model_step();
    exp_t e;
    bit sof, gate, apply, fall;
    int nm;
    if (!rst_n) begin
      m_mode = IDLE; m_en = 0; m_sel_sh = 0; m_th_sh = int'(TH_DEF); m_pend = 0;
      m_sel = 0; m_th = int'(TH_DEF); m_prev_vs = 0; m_prev_de = 0;
      m_run = 0; m_len = 0; m_lines = 0; m_flines = 0;
      e.rst = 1; e.vs = 0; e.hs = 0; e.de = 0; e.rgb = 0;
      e.th = TH_DEF; e.sel = 0; e.busy = 0;
      sq.push_back(e);
      return;
    end
    if (cfg_rd) rq.push_back(reg_value(cfg_addr));
    sof = (pre_frame_vsync == VS_POL) && (m_prev_vs != VS_POL);
    nm = m_mode; gate = 0; apply = 0;
    case (m_mode)
      IDLE:     if (m_en) nm = WAIT_SOF;
      WAIT_SOF: if (!m_en) nm = IDLE;
                else if (sof) begin gate = 1; apply = 1; nm = RUN; end
      RUN:      begin gate = 1; apply = sof; if (!m_en) nm = DRAIN; end
      default:  if (m_en) begin gate = 1; nm = RUN; end
                else if (sof) nm = IDLE;
                else gate = 1;
    endcase
    if (apply) begin m_sel = m_sel_sh; m_th = m_th_sh; end
    if (cfg_wr && cfg_addr == 2'd0) begin m_en = cfg_wdata[0]; m_sel_sh = int'(cfg_wdata[2:1]); end
    if (cfg_wr && cfg_addr == 2'd1) m_th_sh = int'(cfg_wdata[10:0]);
    if (cfg_wr && cfg_addr <= 2'd1) m_pend = 1;
    else if (apply) m_pend = 0;
    fall = m_prev_de && !pre_frame_de;
    if (fall) begin m_len = m_run; m_lines = sat(m_lines + 1); end
    m_run = pre_frame_de ? sat(m_run + 1) : 0;
    if (sof) begin m_flines = m_lines; m_lines = 0; end
    else if (cfg_wr && cfg_addr == 2'd3) m_flines = 0;
    m_mode = nm; m_prev_vs = pre_frame_vsync; m_prev_de = pre_frame_de;
    e.rst = 0; e.vs = pre_frame_vsync; e.hs = pre_frame_hsync;
    e.de = pre_frame_de & gate; e.rgb = pre_rgb;
    e.th = 11'(m_th); e.sel = 2'(m_sel); e.busy = (nm == RUN) || (nm == DRAIN);
    sq.push_back(e);
  endfunction

  // Monitor
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= cfg_rd && rst_n;

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] r;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("pipe_vsync", 32'(pipe_frame_vsync), 32'(e.vs));
      chk("pipe_hsync", 32'(pipe_frame_hsync), 32'(e.hs));
      chk("pipe_de",    32'(pipe_frame_de),    32'(e.de));
      chk("pipe_rgb",   32'(pipe_rgb),         32'(e.rgb));
      chk("sobel_th",   32'(sobel_th),         32'(e.th));
      chk("out_sel",    32'(out_sel),          32'(e.sel));
      chk("vip_busy",   32'(vip_busy),         32'(e.busy));
      if (e.rst) chk("rdata_reset", 32'(cfg_rdata), 32'd0);
    end
    if (rd_seen) begin
      if (rq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rd_queue: read response 0x%0h with no expectation", cfg_rdata);
      end else begin
        r = rq.pop_front();
        chk("cfg_rdata", 32'(cfg_rdata), 32'(r));
      end
    end
  end

  // Stimulus
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    cfg_wr = 1'b0;
    cfg_rd = 1'b0;
  endtask

  task automatic rnd_cfg();
    if (rnd_on && !cfg_wr && !cfg_rd && $urandom_range(0, 99) < 4) begin
      cfg_addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        cfg_wr    = 1'b1;
        cfg_wdata = 16'($urandom);
        if (cfg_addr == 2'd0) cfg_wdata[0] = ($urandom_range(0, 3) != 0);
      end else begin
        cfg_rd = 1'b1;
      end
    end
  endtask

  task automatic idle_cyc(int n);
    for (int i = 0; i < n; i++) begin
      pre_frame_de = 1'b0; pre_frame_hsync = 1'b0; pre_rgb = 16'($urandom);
      rnd_cfg(); cyc();
    end
  endtask

  task automatic sync_pulse(bit do_wr, logic [1:0] a, logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      pre_frame_vsync = VS_POL; pre_frame_de = 1'b0; pre_frame_hsync = 1'b0;
      pre_rgb = 16'($urandom);
      if (i == 0 && do_wr) begin cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d; end
      rnd_cfg(); cyc();
    end
    pre_frame_vsync = ~VS_POL;
    idle_cyc(2);
  endtask

  task automatic lines(int n, int len, int last, int blank);
    int ll;
    for (int l = 0; l < n; l++) begin
      ll = (l == n - 1) ? last : len;
      for (int p = 0; p < ll; p++) begin
        pre_frame_de = 1'b1; pre_frame_hsync = 1'b1; pre_rgb = 16'($urandom);
        rnd_cfg(); cyc();
      end
      idle_cyc(blank);
    end
  endtask

  task automatic cfg_write(logic [1:0] a, logic [15:0] d);
    pre_frame_de = 1'b0; cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
  endtask

  task automatic cfg_read(logic [1:0] a);
    pre_frame_de = 1'b0; cfg_rd = 1'b1; cfg_addr = a;
    cyc();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pre_frame_de = i[0]; pre_rgb = 16'($urandom); cyc();
    end
    pre_frame_de = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) cfg_read(2'(a));
    lines(4, 5, 5, 2);

    // Enable mid-frame: gate opens at the following SOF with out_sel 2
    sync_pulse(0, 0, 0);
    lines(3, 6, 6, 2);
    cfg_write(0, 16'h0005);
    cfg_read(2);
    lines(3, 6, 6, 2);
    sync_pulse(0, 0, 0);
    lines(4, 6, 6, 2);

    // Threshold update held until the next SOF
    cfg_write(1, 16'd300);
    cfg_read(2);
    lines(2, 6, 6, 2);
    sync_pulse(0, 0, 0);
    cfg_read(2);
    cfg_read(1);
    lines(2, 6, 6, 2);

    // Disable mid-frame: drain, then idle at the next SOF
    cfg_write(0, 16'h0004);
    lines(3, 6, 6, 2);
    sync_pulse(0, 0, 0);
    lines(3, 6, 6, 2);
    cfg_read(2);

    // Geometry: 480 lines, last line 640 wide
    cfg_write(0, 16'h0005);
    sync_pulse(0, 0, 0);
    lines(480, 8, 640, 2);
    sync_pulse(0, 0, 0);
    cfg_read(2);
    cfg_read(3);
    cfg_write(3, 16'h0000);
    cfg_read(3);

    // Threshold write coincident with SOF
    lines(2, 5, 5, 2);
    sync_pulse(1, 2'd1, 16'hFA2B);
    cfg_read(2);
    cfg_read(1);
    lines(2, 5, 5, 2);
    sync_pulse(0, 0, 0);
    cfg_read(2);
    lines(2, 5, 5, 2);

    // Read and write to the same register in one cycle
    pre_frame_de = 1'b0; cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd77;
    cyc();
    cfg_read(1);

    // Asynchronous reset mid-frame
    sync_pulse(0, 0, 0);
    lines(3, 6, 6, 2);
    rst_n = 1'b0;
    lines(2, 5, 5, 1);
    rst_n = 1'b1;
    lines(2, 5, 5, 2);
    for (int a = 0; a < 4; a++) cfg_read(2'(a));
    cfg_write(0, 16'h0007);
    sync_pulse(0, 0, 0);
    lines(3, 6, 6, 2);
    sync_pulse(0, 0, 0);

    // Saturation of line length and line count
    lines(1, 4100, 4100, 2);
    cfg_read(2);
    sync_pulse(0, 0, 0);
    lines(4100, 1, 1, 1);
    sync_pulse(0, 0, 0);
    cfg_read(3);

    // Random frames with random register traffic
    rnd_on = 1;
    for (int f = 0; f < 25; f++) begin
      sync_pulse(0, 0, 0);
      lines($urandom_range(1, 8), $urandom_range(1, 20), $urandom_range(1, 20),
            $urandom_range(1, 4));
      idle_cyc($urandom_range(0, 5));
    end
    rnd_on = 0;
    idle_cyc(3);
    for (int a = 0; a < 4; a++) cfg_read(2'(a));
    idle_cyc(2);

    n_chk++;
    if (sq.size() != 0 || rq.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d stream and %0d read expectations unconsumed, required 0",
               sq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
